// File: rtl/fc_pkg.sv
// Shared state encoding and UART framing constants for the telemetry FIFO drain path.
package fc_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
    STOP
  } drain_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } uart_phase_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first serializer: a load pulse starts the start bit on the next cycle; frame is 10*CLK_DIV cycles.
// No backpressure: the caller loads only when idle; done pulses on the last cycle of the stop bit.
module uart_tx_serializer
  import fc_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       start_end,
  output logic       data_end
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_phase_t   phase;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_end;

  assign baud_end  = (baud_cnt == BAUD_MAX);
  assign start_end = (phase == PH_START) && baud_end;
  assign data_end  = (phase == PH_DATA) && baud_end && (bit_idx == LAST_BIT);
  assign done      = (phase == PH_STOP) && baud_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load) begin
      phase    <= PH_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= data;
    end else if (phase != PH_IDLE) begin
      if (baud_end) begin
        baud_cnt <= '0;
        case (phase)
          PH_START: phase <= PH_DATA;
          PH_DATA: begin
            // Shift right so the next bit to send is always shreg[0].
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) phase <= PH_STOP;
          end
          PH_STOP: phase <= PH_IDLE;
          default: phase <= PH_IDLE;
        endcase
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (phase)
      PH_START: tx = 1'b0;
      PH_DATA:  tx = shreg[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains a standard-mode FIFO in bursts onto an 8N1 UART; tx falls 2 cycles after each rd_en pulse.
// Backpressure: never reads while empty; a burst ends early on empty FIFO or enable low.
module fifo_uart_drain
  import fc_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic [12:0] fifo_rd_data_count,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [12:0]   BURST_INIT = 13'(BURST_LEN);

  drain_state_t  state, state_nxt;
  logic [12:0]   burst_rem;
  logic [TW-1:0] timer;
  logic          burst_go;
  logic          ser_load;
  logic          ser_done;
  logic          ser_start_end;
  logic          ser_data_end;

  uart_tx_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .data      (fifo_dout),
    .tx        (tx),
    .done      (ser_done),
    .start_end (ser_start_end),
    .data_end  (ser_data_end)
  );

  always_comb begin
    burst_go   = enable && !fifo_empty &&
                 ((fifo_rd_data_count >= BURST_INIT) || (timer == TIMER_MAX));
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    ser_load   = 1'b0;
    case (state)
      IDLE: if (burst_go) state_nxt = READ;
      READ: begin
        // Empty gating keeps the read strobe safe even if the flag moves under us.
        if (fifo_empty) begin
          state_nxt = IDLE;
        end else begin
          fifo_rd_en = 1'b1;
          state_nxt  = LATCH;
        end
      end
      LATCH: begin
        ser_load  = 1'b1;
        state_nxt = START;
      end
      START: if (ser_start_end) state_nxt = DATA;
      DATA:  if (ser_data_end) state_nxt = STOP;
      STOP: begin
        if (ser_done) begin
          state_nxt = ((burst_rem != 13'd0) && !fifo_empty && enable) ? READ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_rem  <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      bytes_sent <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);

      if (state == IDLE) begin
        if (burst_go || fifo_empty) timer <= '0;
        else if (timer != TIMER_MAX) timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end

      if ((state == IDLE) && burst_go) burst_rem <= BURST_INIT;
      else if (fifo_rd_en)             burst_rem <= burst_rem - 13'd1;

      if (ser_done) bytes_sent <= bytes_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench: FIFO model, UART decoder, table-driven bursts plus timeout/enable/reset sequences.
module tb_fifo_uart_drain;

  localparam int CLK_DIV   = 4;
  localparam int BURST_LEN = 64;
  localparam int TIMEOUT   = 100;
  localparam int FRAME     = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic [12:0] fifo_rd_data_count;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;

  always #5 clk = ~clk;

  fifo_uart_drain #(
    .CLK_DIV  (CLK_DIV),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .fifo_dout         (fifo_dout),
    .fifo_empty        (fifo_empty),
    .fifo_rd_data_count(fifo_rd_data_count),
    .fifo_rd_en        (fifo_rd_en),
    .tx                (tx),
    .busy              (busy),
    .bytes_sent        (bytes_sent)
  );

  // Standard-mode FIFO model: data appears the cycle after rd_en.
  logic [7:0] mem [0:1023];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  force_count = 1'b0;

  assign fifo_empty         = (rd_ptr >= wr_ptr);
  assign fifo_rd_data_count = force_count ? 13'd64 : 13'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Line monitor and 8N1 decoder, sampled mid-cycle.
  int         cyc = 0;
  int         rd_pulses = 0;
  int         underflows = 0;
  int         frame_errs = 0;
  int         rd_cyc[$];
  int         fall_cyc[$];
  logic [7:0] rx_q[$];
  bit         dec_busy = 1'b0;
  int         dec_t = 0;
  int         dk;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      rd_pulses  = 0;
      underflows = 0;
      frame_errs = 0;
      rd_cyc.delete();
      fall_cyc.delete();
      rx_q.delete();
      dec_busy = 1'b0;
      dec_t    = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_pulses = rd_pulses + 1;
        rd_cyc.push_back(cyc);
        if (fifo_empty) underflows = underflows + 1;
      end
      if (!dec_busy) begin
        if (tx == 1'b0) begin
          dec_busy = 1'b1;
          dec_t    = 0;
          fall_cyc.push_back(cyc);
        end
      end else begin
        dec_t = dec_t + 1;
        if ((dec_t % CLK_DIV) == (CLK_DIV / 2)) begin
          dk = dec_t / CLK_DIV;
          if (dk == 0) begin
            if (tx !== 1'b0) frame_errs = frame_errs + 1;
          end else if (dk <= 8) begin
            dec_byte[dk-1] = tx;
          end else begin
            if (tx !== 1'b1) frame_errs = frame_errs + 1;
            rx_q.push_back(dec_byte);
            dec_busy = 1'b0;
          end
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst         = 1'b1;
    force_count = 1'b0;
    wr_ptr      = rd_ptr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_idle(output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    if (busy) begin
      n = 0;
      while (busy && n < 6000) begin
        @(negedge clk);
        n = n + 1;
      end
      ok = !busy;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_data(input string tag, input logic [7:0] base, input int n);
    int mism;
    logic [7:0] exp_b;
    mism = 0;
    for (int j = 0; j < rx_q.size() && j < n; j++) begin
      exp_b = base + 8'(j);
      if (rx_q[j] != exp_b) mism = mism + 1;
    end
    check({tag, "_rx_count"}, rx_q.size(), n);
    check({tag, "_rx_data_mismatches"}, mism, 0);
  endtask

  task automatic check_timing(input string tag);
    int bad_lat;
    int bad_gap;
    bad_lat = 0;
    bad_gap = 0;
    for (int j = 0; j < fall_cyc.size(); j++) begin
      if (j >= rd_cyc.size() || (fall_cyc[j] - rd_cyc[j]) != 2) bad_lat = bad_lat + 1;
      if (j > 0 && (fall_cyc[j] - fall_cyc[j-1]) != FRAME + 2) bad_gap = bad_gap + 1;
    end
    check({tag, "_rd_to_tx_fall"}, bad_lat, 0);
    check({tag, "_interframe_gap"}, bad_gap, 0);
  endtask

  typedef struct {
    int         nbytes;
    logic [7:0] base;
    bit         force64;
    bit         en;
    int         exp_frames;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit         ok;
    int         k;
    int         cnt;
    int         mism;
    logic [7:0] tmo_bytes [3];

    vecs[0] = '{64, 8'h00, 1'b0, 1'b1, 64};  // full burst
    vecs[1] = '{10, 8'h30, 1'b1, 1'b1, 10};  // count says 64, only 10 readable
    vecs[2] = '{70, 8'h10, 1'b0, 1'b1, 64};  // burst capped at BURST_LEN
    vecs[3] = '{64, 8'h00, 1'b0, 1'b0, 0};   // enable low: nothing drained

    // Reset state
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_bytes_sent", bytes_sent, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      apply_reset();
      force_count = vecs[i].force64;
      enable      = vecs[i].en;
      for (int j = 0; j < vecs[i].nbytes; j++) push_byte(vecs[i].base + 8'(j));
      run_to_idle(ok);
      check($sformatf("v%0d_idle_reached", i), ok, 1);
      check($sformatf("v%0d_rd_pulses", i), rd_pulses, vecs[i].exp_frames);
      check($sformatf("v%0d_bytes_sent", i), bytes_sent, vecs[i].exp_frames);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_tx_idle", i), tx, 1);
      check($sformatf("v%0d_underflows", i), underflows, 0);
      check($sformatf("v%0d_frame_errs", i), frame_errs, 0);
      check_data($sformatf("v%0d", i), vecs[i].base, vecs[i].exp_frames);
    end

    // Timeout flush of a short tail
    tmo_bytes[0] = 8'hA5;
    tmo_bytes[1] = 8'h5A;
    tmo_bytes[2] = 8'hFF;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) push_byte(tmo_bytes[j]);
    k = 0;
    while (!fifo_rd_en && k < 300) begin
      @(negedge clk);
      k = k + 1;
    end
    check("timeout_first_read_latency", k, TIMEOUT + 1);
    run_to_idle(ok);
    check("timeout_idle_reached", ok, 1);
    check("timeout_rd_pulses", rd_pulses, 3);
    check("timeout_bytes_sent", bytes_sent, 3);
    check("timeout_busy", busy, 0);
    check("timeout_rx_count", rx_q.size(), 3);
    mism = 0;
    for (int j = 0; j < rx_q.size() && j < 3; j++)
      if (rx_q[j] != tmo_bytes[j]) mism = mism + 1;
    check("timeout_rx_data_mismatches", mism, 0);
    check_timing("timeout");

    // Enable dropped during the 5th frame's data bits
    apply_reset();
    enable = 1'b1;
    for (int j = 0; j < 64; j++) push_byte(8'(j));
    cnt = 0;
    k   = 0;
    while (cnt < 5 && k < 1000) begin
      @(negedge clk);
      k = k + 1;
      if (fifo_rd_en) cnt = cnt + 1;
    end
    check("endrop_reached_5th_read", cnt, 5);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    run_to_idle(ok);
    check("endrop_idle_reached", ok, 1);
    check("endrop_rd_pulses", rd_pulses, 5);
    check("endrop_bytes_sent", bytes_sent, 5);
    check("endrop_tx_idle", tx, 1);
    check("endrop_frame_errs", frame_errs, 0);
    check_data("endrop", 8'h00, 5);

    // Reset in the middle of the 2nd frame, then recovery via timeout flush
    apply_reset();
    enable = 1'b1;
    for (int j = 0; j < 64; j++) push_byte(8'h40 + 8'(j));
    cnt = 0;
    k   = 0;
    while (cnt < 2 && k < 1000) begin
      @(negedge clk);
      k = k + 1;
      if (fifo_rd_en) cnt = cnt + 1;
    end
    repeat (10) @(negedge clk);
    check("rstmid_tx_low_before", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx", tx, 1);
    check("rstmid_bytes_sent", bytes_sent, 0);
    check("rstmid_rd_en", fifo_rd_en, 0);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_to_idle(ok);
    check("rstmid_idle_reached", ok, 1);
    check("rstmid_rd_pulses", rd_pulses, 62);
    check("rstmid_bytes_sent_after", bytes_sent, 62);
    check("rstmid_underflows", underflows, 0);
    check("rstmid_frame_errs", frame_errs, 0);
    check_data("rstmid", 8'h42, 62);
    check_timing("rstmid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
